// File: rtl/alu_normalizer32.sv
// Binary-search normalizer: leading-zero / redundant-sign-bit count, one stage per clock.
// Optional ALU_NORM_EARLY_DONE_EN: finish as soon as the working value is normalized.
module alu_normalizer32 #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in,
  input  logic              signed_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out,
  output logic [CNT_W-1:0]  shiftby,
  output logic              zero
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] w;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  stg;
  logic              sgn;
  logic              zq;

  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] t;
  logic [DATA_W-1:0] mask;
  logic              hit;
  logic              in_zero;

  // stg is one-hot and doubles as the shift amount of the current stage
  assign d       = w ^ {w[DATA_W-2:0], 1'b0};
  assign t       = sgn ? d : w;
  assign mask    = ~({DATA_W{1'b1}} >> stg);
  assign hit     = (t & mask) == '0;
  assign in_zero = (in == '0) || (signed_mode && (in == '1));

`ifdef ALU_NORM_EARLY_DONE_EN
  logic norm;
  assign norm = sgn ? (w[DATA_W-1] ^ w[DATA_W-2]) : w[DATA_W-1];
`endif

  assign out     = w;
  assign shiftby = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      zero      <= 1'b0;
      w         <= '0;
      cnt       <= '0;
      stg       <= '0;
      sgn       <= 1'b0;
      zq        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            w        <= in;
            cnt      <= '0;
            sgn      <= signed_mode;
            zq       <= in_zero;
            stg      <= CNT_W'(16);
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
`ifdef ALU_NORM_EARLY_DONE_EN
          if (norm) begin
            state     <= DONE;
            out_valid <= 1'b1;
            zero      <= zq;
          end else
`endif
          begin
            if (hit) begin
              w   <= w << stg;
              cnt <= cnt + stg;
            end
            stg <= stg >> 1;
            if (stg[0]) begin
              state     <= DONE;
              out_valid <= 1'b1;
              zero      <= zq;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            zero      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
